// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} b2b_state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Bits needed to hold 10**digits - 1, i.e. ceil(log2(10**digits)).
  function automatic int bin_width(int digits);
    longint unsigned p;
    longint unsigned one;
    int              w;
    p   = 1;
    one = 1;
    w   = 0;
    for (int i = 0; i < digits; i++) p = p * 10;
    while ((one << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double dabble: a digit that picked up a
// borrowed half-ten (>=8 after the shift) is reduced by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per clock.
// Invalid BCD digits are flagged immediately without entering the shift loop.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_i,
  output logic                        ready_o,
  output logic                        valid_o,
  output logic [BIN_W-1:0]            bin_o,
  output logic                        err_o
);

  localparam int N     = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(N + 1);

  if (BIN_W < bin_width(DIGITS)) begin : g_width_check
    $error("bcd_to_bin_seq: BIN_W too narrow for DIGITS");
  end

  b2b_state_t        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [N-1:0]      bcd_q, acc_q;
  logic [N-1:0]      bcd_shift, bcd_d, acc_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              ready_q, valid_q, err_q;
  logic [DIGITS-1:0] digit_bad;
  logic              last_shift;

  assign bcd_shift  = bcd_q >> 1;
  assign acc_d      = {bcd_q[0], acc_q[N-1:1]};
  assign last_shift = (count_q == CNT_W'(N - 1));
  // After N shifts the whole value sits in the low bits of acc; the rest are zero.
  assign bin_d      = BIN_W'(acc_d);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign digit_bad[g] = (bcd_i[g*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT);
    bcd_digit_adjust u_adj (
      .d_i (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (bcd_d[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift datapath: loaded on any idle request, shifted every SHIFT cycle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (start_i) begin
        bcd_q <= bcd_i;
        acc_q <= '0;
      end
    end else begin
      bcd_q <= bcd_d;
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start_i) begin
          if (|digit_bad) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            bin_q   <= '0;
          end else begin
            state_q <= SHIFT;
            ready_q <= 1'b0;
            count_q <= '0;
          end
        end
      end else begin
        count_q <= count_q + 1'b1;
        if (last_shift) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
          bin_q   <= bin_d;
        end
      end
    end
  end

  // Every BCD bit must have been consumed by the final shift.
  always @(posedge clk) begin
    if (!rst && state_q == SHIFT && last_shift) begin
      assert (bcd_d == '0);
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq (DIGITS=3, BIN_W=10): vector table, corner
// sequences, random and exhaustive runs against an arithmetic decimal model.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [11:0] bcd_i;
  logic        ready_o;
  logic        valid_o;
  logic [9:0]  bin_o;
  logic        err_o;

  int n_tests;
  int n_fail;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .bcd_i   (bcd_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .bin_o   (bin_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal model: digit >9 is an error, otherwise sum of digit * 10**i.
  function automatic logic [10:0] model(input logic [11:0] b);
    int v;
    int d;
    v = 0;
    for (int i = 2; i >= 0; i--) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) return {1'b1, 10'd0};
      v = v * 10 + d;
    end
    return {1'b0, 10'(v)};
  endfunction

  // One request from idle; noise on start_i/bcd_i while busy must be ignored.
  task automatic do_conv(input string name, input logic [11:0] bcd,
                         input logic [9:0] exp_bin, input logic exp_err);
    int          lat;
    logic        rdy_after;
    logic [9:0]  got_bin;
    start_i = 1'b1;
    bcd_i   = bcd;
    tick();
    rdy_after = ready_o;
    lat = 0;
    while (!valid_o && lat < 40) begin
      start_i = 1'($urandom_range(0, 1));
      bcd_i   = 12'($urandom);
      tick();
      lat++;
    end
    start_i = 1'b0;
    check({name, " valid"}, int'(valid_o), 1);
    check({name, " latency"}, lat, exp_err ? 0 : 12);
    check({name, " bin"}, int'(bin_o), int'(exp_bin));
    check({name, " err"}, int'(err_o), int'(exp_err));
    check({name, " ready_after_accept"}, int'(rdy_after), int'(exp_err));
    got_bin = bin_o;
    tick();
    check({name, " valid_pulse"}, int'(valid_o), 0);
    check({name, " bin_hold"}, int'(bin_o), int'(got_bin));
    check({name, " ready_idle"}, int'(ready_o), 1);
  endtask

  initial begin
    vec_t        tbl[10];
    logic [10:0] m;
    logic [11:0] r;
    int          cyc;
    int          nval;
    int          vcyc[2];
    int          vbin[2];

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start_i = 1'b0;
    bcd_i   = '0;

    tbl[0] = '{12'h255, 10'd255, 1'b0};
    tbl[1] = '{12'h999, 10'h3E7, 1'b0};
    tbl[2] = '{12'h000, 10'd0,   1'b0};
    tbl[3] = '{12'h1A0, 10'd0,   1'b1};
    tbl[4] = '{12'h042, 10'd42,  1'b0};
    tbl[5] = '{12'h100, 10'd100, 1'b0};
    tbl[6] = '{12'hF00, 10'd0,   1'b1};
    tbl[7] = '{12'h009, 10'd9,   1'b0};
    tbl[8] = '{12'h00A, 10'd0,   1'b1};
    tbl[9] = '{12'h321, 10'd321, 1'b0};

    #12;
    check("reset ready", int'(ready_o), 1);
    check("reset valid", int'(valid_o), 0);
    check("reset bin", int'(bin_o), 0);
    check("reset err", int'(err_o), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      do_conv($sformatf("tbl%0d", i), tbl[i].bcd, tbl[i].bin, tbl[i].err);

    // Back-to-back: start held through the second accept, bcd_i changed mid-run.
    start_i = 1'b1;
    bcd_i   = 12'h042;
    nval    = 0;
    cyc     = 0;
    tick();
    bcd_i = 12'h100;
    for (cyc = 1; cyc <= 32; cyc++) begin
      tick();
      if (valid_o) begin
        if (nval < 2) begin
          vcyc[nval] = cyc;
          vbin[nval] = int'(bin_o);
        end
        nval++;
      end
      if (cyc == 12) check("b2b ready_at_12", int'(ready_o), 1);
      if (cyc == 13) begin
        check("b2b ready_at_13", int'(ready_o), 0);
        start_i = 1'b0;
      end
    end
    check("b2b valid_count", nval, 2);
    if (nval >= 2) begin
      check("b2b first_edge", vcyc[0], 12);
      check("b2b first_bin", vbin[0], 42);
      check("b2b second_edge", vcyc[1], 25);
      check("b2b second_bin", vbin[1], 100);
    end

    // Reset in the middle of a conversion.
    start_i = 1'b1;
    bcd_i   = 12'h777;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst ready", int'(ready_o), 1);
    check("midrst valid", int'(valid_o), 0);
    check("midrst bin", int'(bin_o), 0);
    check("midrst err", int'(err_o), 0);
    tick();
    tick();
    rst  = 1'b0;
    nval = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (valid_o) nval++;
    end
    check("midrst no_valid", nval, 0);
    do_conv("after_rst", 12'h321, 10'd321, 1'b0);

    // Random 12-bit requests, valid and invalid mixed.
    for (int i = 0; i < 150; i++) begin
      r = 12'($urandom);
      m = model(r);
      do_conv($sformatf("rand_%03h", r), r, m[9:0], m[10]);
    end

    // Exhaustive over every legal value.
    for (int v = 0; v < 1000; v++) begin
      r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      m = model(r);
      do_conv($sformatf("exh_%03h", r), r, m[9:0], m[10]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
